// File: rtl/bridge_byte_ram_leaf.sv
// Bridge-side responder leaf for a byte-wide dual-port RAM.
// Port A serves host 32-bit big-endian bridge words as four byte accesses.
// Port B gives the core byte access with 1-cycle registered read data.
// A one-deep hold buffer absorbs a write that arrives while the serializer is busy.
// Optional feature macro: BRIDGE_BYTE_RAM_DIRTY_TRACK_EN (core-write dirty flag).
// Handshake: bridge_wr/bridge_rd are single-cycle strobes with no ready; the host
// observes busy, and bridge_rd_data holds the last completed read word.
module bridge_byte_ram_leaf #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_BYTES = 256,
  localparam int         AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   bridge_addr,
  input  logic          bridge_wr,
  input  logic [31:0]   bridge_wr_data,
  input  logic          bridge_rd,
  output logic [31:0]   bridge_rd_data,
  output logic          busy,
  output logic [7:0]    drop_count,
  input  logic [AW-1:0] core_addr,
  input  logic          core_wr,
  input  logic [7:0]    core_wdata,
  output logic [7:0]    core_rdata,
  output logic          dirty,
  output logic [3:0]    fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR0, S_WR1, S_WR2, S_WR3, S_RD0, S_RD1, S_RD2, S_RD3, S_RDW
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [7:0]    ra_q;
  logic [23:0]   shift_q;

  logic [AW-1:0] cur_off;
  logic [31:0]   cur_data;
  logic          cur_oor;
  logic          hold_v_q;
  logic [AW-1:0] hold_off;
  logic [31:0]   hold_data;
  logic          rd_pend_q;
  logic [AW-1:0] rd_off_q;
  logic          rd_oor_q;

  logic [31:0]   off;
  logic          in_range, wr_hit, rd_active, rd_accept;
  logic          load_new, load_hold_cur, hold_set, drop, start_rd, rd_done, a_we;
  logic [1:0]    idx;
  logic [AW-1:0] a_addr;
  logic [7:0]    a_wdata;

  assign off       = bridge_addr - BASE_ADDR;
  assign in_range  = off < 32'(DEPTH_BYTES);
  assign wr_hit    = bridge_wr && in_range;
  assign rd_active = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_RD2) ||
                     (state_q == S_RD3) || (state_q == S_RDW);
  assign rd_accept = bridge_rd && !rd_pend_q && !rd_active;
  assign a_addr    = cur_off + AW'(idx);
  assign busy      = (state_q != S_IDLE) || hold_v_q;
  assign fsm_state = state_q;

  // Next-state and per-cycle port-A controls; writes take priority over a pending read.
  always_comb begin
    state_d       = state_q;
    load_new      = 1'b0;
    load_hold_cur = 1'b0;
    hold_set      = 1'b0;
    drop          = 1'b0;
    start_rd      = 1'b0;
    rd_done       = 1'b0;
    a_we          = 1'b0;
    idx           = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (wr_hit) begin
          state_d  = S_WR0;
          load_new = 1'b1;
        end else if (rd_pend_q) begin
          state_d  = S_RD0;
          start_rd = 1'b1;
        end
      end
      S_WR0: begin a_we = 1'b1; idx = 2'd0; state_d = S_WR1; end
      S_WR1: begin a_we = 1'b1; idx = 2'd1; state_d = S_WR2; end
      S_WR2: begin a_we = 1'b1; idx = 2'd2; state_d = S_WR3; end
      S_WR3: begin
        a_we = 1'b1;
        idx  = 2'd3;
        if (hold_v_q) begin
          state_d       = S_WR0;
          load_hold_cur = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD0: begin idx = 2'd0; state_d = S_RD1; end
      S_RD1: begin idx = 2'd1; state_d = S_RD2; end
      S_RD2: begin idx = 2'd2; state_d = S_RD3; end
      S_RD3: begin idx = 2'd3; state_d = S_RDW; end
      S_RDW: begin
        rd_done = 1'b1;
        if (hold_v_q) begin
          state_d       = S_WR0;
          load_hold_cur = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_hit && (state_q != S_IDLE)) begin
      if (hold_v_q) drop = 1'b1;
      else          hold_set = 1'b1;
    end
    // Reset aborts a word mid-flight: the byte of this cycle must not land.
    if (reset) a_we = 1'b0;
  end

  // Byte lane of the current word for port A, MSB lane at the lowest address.
  always_comb begin
    case (idx)
      2'd0:    a_wdata = cur_data[31:24];
      2'd1:    a_wdata = cur_data[23:16];
      2'd2:    a_wdata = cur_data[15:8];
      default: a_wdata = cur_data[7:0];
    endcase
  end

  // Control state: FSM, hold/pending flags, drop counter, read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      hold_v_q       <= 1'b0;
      rd_pend_q      <= 1'b0;
      drop_count     <= 8'd0;
      bridge_rd_data <= 32'd0;
    end else begin
      state_q <= state_d;
      if (hold_set)           hold_v_q <= 1'b1;
      else if (load_hold_cur) hold_v_q <= 1'b0;
      if (rd_accept)          rd_pend_q <= 1'b1;
      else if (start_rd)      rd_pend_q <= 1'b0;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (rd_done) bridge_rd_data <= cur_oor ? 32'd0 : {shift_q, ra_q};
    end
  end

  // Datapath registers: active word, hold word, pending read address, byte shifter.
  always_ff @(posedge clk) begin
    if (load_new) begin
      cur_off  <= off[AW-1:0];
      cur_data <= bridge_wr_data;
    end else if (load_hold_cur) begin
      cur_off  <= hold_off;
      cur_data <= hold_data;
    end else if (start_rd) begin
      cur_off <= rd_off_q;
      cur_oor <= rd_oor_q;
    end
    if (hold_set) begin
      hold_off  <= off[AW-1:0];
      hold_data <= bridge_wr_data;
    end
    if (rd_accept) begin
      rd_off_q <= off[AW-1:0];
      rd_oor_q <= !in_range;
    end
    if ((state_q == S_RD1) || (state_q == S_RD2) || (state_q == S_RD3))
      shift_q <= {shift_q[15:0], ra_q};
  end

  // Dual-port byte RAM; a same-byte collision resolves to the bridge write.
  always_ff @(posedge clk) begin
    if (core_wr) mem[core_addr] <= core_wdata;
    if (a_we)    mem[a_addr]    <= a_wdata;
    core_rdata <= mem[core_addr];
    ra_q       <= mem[a_addr];
  end

`ifdef BRIDGE_BYTE_RAM_DIRTY_TRACK_EN
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_BYTES - 4);
  logic dirty_q;
  // Dirty flag: core write sets, completed in-range read of the last word clears.
  always_ff @(posedge clk) begin
    if (reset)                                        dirty_q <= 1'b0;
    else if (core_wr)                                 dirty_q <= 1'b1;
    else if (rd_done && !cur_oor && cur_off == LAST_WORD) dirty_q <= 1'b0;
  end
  assign dirty = dirty_q;
`else
  assign dirty = 1'b0;
`endif

endmodule
